// File: rtl/dpram_pkg.sv
// Shared types for the byte-enable dual-port RAM: read-during-write mode
// and the clear engine state encoding.
package dpram_pkg;

  typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_t;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/dpram_clear_fsm.sv
// Clear engine: sweeps every word from address 0 upward, one per clock,
// while it owns the array. Reset parks it in CLEAR so power-up self-clears.
module dpram_clear_fsm import dpram_pkg::*; #(
  parameter int addr_width = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [addr_width-1:0] clr_addr
);

  localparam logic [addr_width-1:0] LAST = '1;

  clr_state_t            state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter holds at LAST on exit; it is reloaded to 0 when a new clear starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) state_d = IDLE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with per-byte write enables, chip selects, a
// configurable read pipeline and a whole-array clear engine.
module dpram_be import dpram_pkg::*; #(
  parameter int                  addr_width    = 8,
  parameter int                  data_width    = 16,
  parameter int                  rd_latency    = 1,
  parameter rdw_mode_t           rdw_mode      = RDW_OLD,
  parameter logic [data_width-1:0] clear_value = '0,
  parameter logic                disable_value = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [addr_width-1:0]   address_a,
  input  logic [addr_width-1:0]   address_b,
  input  logic [data_width-1:0]   data_a,
  input  logic [data_width-1:0]   data_b,
  input  logic [data_width/8-1:0] byteena_a,
  input  logic [data_width/8-1:0] byteena_b,
  input  logic                    enable_a,
  input  logic                    enable_b,
  input  logic                    wren_a,
  input  logic                    wren_b,
  input  logic                    cs_a,
  input  logic                    cs_b,
  output logic [data_width-1:0]   q_a,
  output logic [data_width-1:0]   q_b,
  input  logic                    clear_req,
  output logic                    busy
);

  localparam int DEPTH = 2**addr_width;
  localparam int NB    = data_width/8;
  localparam int NP    = 2;

  logic [NP-1:0][addr_width-1:0] addr;
  logic [NP-1:0][data_width-1:0] wdata, q;
  logic [NP-1:0][NB-1:0]         be;
  logic [NP-1:0]                 en, cs, wr, we;
  logic [addr_width-1:0]         clr_addr;

  logic [data_width-1:0] mem [DEPTH];

  assign addr  = {address_b, address_a};
  assign wdata = {data_b, data_a};
  assign be    = {byteena_b, byteena_a};
  assign en    = {enable_b, enable_a};
  assign cs    = {cs_b, cs_a};
  assign wr    = {wren_b, wren_a};
  assign q_a   = q[0];
  assign q_b   = q[1];

  dpram_clear_fsm #(.addr_width(addr_width)) u_clr (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_addr (clr_addr)
  );

  // Port B is applied first so port A's bytes land last and win collisions.
  always_ff @(posedge clock) begin
    if (busy) begin
      mem[clr_addr] <= clear_value;
    end else begin
      for (int p = NP-1; p >= 0; p--) begin
        if (we[p]) begin
          for (int b = 0; b < NB; b++) begin
            if (be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [data_width-1:0]                 old_w, merged_w, rd_w;
    logic [rd_latency-1:0][data_width-1:0] pipe_q;

    assign old_w = mem[addr[p]];
    assign we[p] = en[p] & cs[p] & wr[p] & ~busy;

    always_comb begin
      merged_w = old_w;
      for (int b = 0; b < NB; b++) begin
        if (be[p][b]) merged_w[b*8 +: 8] = wdata[p][b*8 +: 8];
      end
    end

    // Only this port's own write is visible in RDW_NEW; the other port's is not.
    assign rd_w = (rdw_mode == RDW_NEW && we[p]) ? merged_w : old_w;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pipe_q <= '0;
      end else if (busy) begin
        pipe_q <= '0;
      end else if (en[p]) begin
        pipe_q[0] <= rd_w;
        for (int i = 1; i < rd_latency; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q[p] = (!cs[p] || busy) ? {data_width{disable_value}} : pipe_q[rd_latency-1];
  end

endmodule
